// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM controller between display burst reads and pixel word writes.
// Reads win when the FIFO runs low; otherwise contending requesters alternate.
module sdram_arbiter #(
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 384000,
  parameter int FIFO_DEPTH  = 1024,
  parameter int FIFO_AW     = 10,
  parameter int LOW_WATER   = 256,
  parameter int WR_MAX      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_enable,
  input  logic [FIFO_AW-1:0] fifo_used,
  output logic               fifo_wr_en,
  output logic [31:0]        fifo_wr_data,
  output logic               frame_ready,
  input  logic               wr_valid,
  input  logic [21:0]        wr_addr,
  input  logic [31:0]        wr_data,
  input  logic               wr_last,
  output logic               wr_ready,
  output logic [1:0]         ctrl_command,
  output logic [21:0]        ctrl_address,
  output logic [31:0]        ctrl_write_data,
  input  logic [31:0]        ctrl_read_data,
  input  logic               ctrl_read_valid,
  input  logic               ctrl_write_done,
  output logic               grant_rd
);
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;
  localparam int UW = FIFO_AW + 1;
  localparam int BW = $clog2((BURST_LEN > WR_MAX ? BURST_LEN : WR_MAX) + 1);
  localparam logic [UW-1:0] RD_ROOM  = UW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [UW-1:0] LOW      = UW'(LOW_WATER);
  localparam logic [BW-1:0] RD_LAST  = BW'(BURST_LEN - 1);
  localparam logic [BW-1:0] WR_LAST  = BW'(WR_MAX - 1);
  localparam logic [21:0]   ADDR_END = 22'(FRAME_WORDS - 1);
  state_t state, next;
  logic [21:0] rd_addr;
  logic [BW-1:0] beat;
  logic last_rd, wr_abort, rd_want, low, rd_beat, wr_done;
  always_comb begin
    rd_want = rd_enable && ({1'b0, fifo_used} <= RD_ROOM);
    low     = {1'b0, fifo_used} < LOW;
    rd_beat = (state == READ) && ctrl_read_valid;
    wr_done = (state == WRITE) && ctrl_write_done;
    next    = state;
    if (state == IDLE)
      next = (rd_want && (low || !wr_valid || !last_rd)) ? READ : wr_valid ? WRITE : IDLE;
    else if ((rd_beat && beat == RD_LAST) || (wr_done && (wr_last || beat == WR_LAST || wr_abort)))
      next = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rd_addr     <= '0;
      beat        <= '0;
      last_rd     <= 1'b0;
      wr_abort    <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE) begin
        beat     <= '0;
        wr_abort <= 1'b0;
        if (next != IDLE) last_rd <= (next == READ);
      end else if (rd_beat || wr_done) begin
        beat <= beat + 1'b1;
      end
      if (rd_beat) rd_addr <= (rd_addr == ADDR_END) ? '0 : rd_addr + 22'd1;
      if (rd_beat && beat == RD_LAST) frame_ready <= 1'b1;
      // a done with no word presented and no last marks the run as broken; leave on the next done
      if (wr_done && !wr_valid && !wr_last) wr_abort <= 1'b1;
    end
  end
  assign ctrl_command    = state;
  assign grant_rd        = (state == READ);
  assign fifo_wr_en      = rd_beat;
  assign fifo_wr_data    = ctrl_read_data;
  assign wr_ready        = wr_done;
  assign ctrl_address    = (state == WRITE) ? wr_addr : rd_addr;
  assign ctrl_write_data = wr_data;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed checks of grants, burst addressing with frame wrap, write runs and reset.
module tb_sdram_arbiter;
  localparam int FW = 20;
  logic clk = 1'b0, rst = 1'b1;
  logic rd_enable = 1'b0, wr_valid = 1'b0, wr_last = 1'b0;
  logic ctrl_read_valid = 1'b0, ctrl_write_done = 1'b0;
  logic [9:0] fifo_used = '0;
  logic [21:0] wr_addr = '0, ctrl_address;
  logic [31:0] wr_data = '0, ctrl_read_data = '0, fifo_wr_data, ctrl_write_data;
  logic fifo_wr_en, frame_ready, wr_ready, grant_rd;
  logic [1:0] ctrl_command;
  int checks = 0, failures = 0, exp_addr = 0;
  sdram_arbiter #(.FRAME_WORDS(FW)) dut (
    .clk(clk), .rst(rst), .rd_enable(rd_enable), .fifo_used(fifo_used),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .frame_ready(frame_ready),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .ctrl_command(ctrl_command), .ctrl_address(ctrl_address),
    .ctrl_write_data(ctrl_write_data), .ctrl_read_data(ctrl_read_data),
    .ctrl_read_valid(ctrl_read_valid), .ctrl_write_done(ctrl_write_done), .grant_rd(grant_rd)
  );
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_grant(input logic [1:0] cmd, input string tag);
    int n = 0;
    while (ctrl_command == 2'd0 && n < 6) begin
      tick();
      n++;
    end
    chk(tag, 32'(ctrl_command), 32'(cmd));
  endtask
  task automatic burst(input int drop_at);
    wait_grant(2'd2, "rd_grant");
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        ctrl_read_valid = 1'b0;
        #1;
        chk("rd_gap_no_push", 32'(fifo_wr_en), 32'd0);
        tick();
      end
      chk("rd_cmd", 32'(ctrl_command), 32'd2);
      ctrl_read_valid = 1'b1;
      ctrl_read_data = 32'hD000_0000 + 32'(exp_addr);
      #1;
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'd1);
      chk("rd_addr", 32'(ctrl_address), 32'(exp_addr));
      chk("fifo_data", fifo_wr_data, 32'hD000_0000 + 32'(exp_addr));
      if (i == drop_at) rd_enable = 1'b0;
      tick();
      exp_addr = (exp_addr + 1) % FW;
    end
    ctrl_read_valid = 1'b0;
    chk("rd_exit", 32'(ctrl_command), 32'd0);
    chk("frame_ready", 32'(frame_ready), 32'd1);
  endtask
  task automatic wgrant(input int n, input logic use_last, input int base);
    wait_grant(2'd1, "wr_grant");
    for (int i = 0; i < n; i++) begin
      chk("wr_cmd", 32'(ctrl_command), 32'd1);
      wr_valid = 1'b1;
      wr_addr = 22'(base + i);
      wr_data = 32'hC000_0000 + 32'(base + i);
      wr_last = use_last && (i == n - 1);
      #1;
      chk("wr_ready_wait", 32'(wr_ready), 32'd0);
      chk("wr_addr", 32'(ctrl_address), 32'(base + i));
      chk("wr_data", ctrl_write_data, 32'hC000_0000 + 32'(base + i));
      ctrl_write_done = 1'b1;
      #1;
      chk("wr_ready", 32'(wr_ready), 32'd1);
      tick();
      ctrl_write_done = 1'b0;
      wr_last = 1'b0;
    end
    chk("wr_exit", 32'(ctrl_command), 32'd0);
  endtask
  initial begin
    #2;
    chk("rst_cmd", 32'(ctrl_command), 32'd0);
    chk("rst_frame_ready", 32'(frame_ready), 32'd0);
    chk("rst_fifo_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_grant_rd", 32'(grant_rd), 32'd0);
    tick();
    rst = 1'b0;
    rd_enable = 1'b1;
    tick();
    chk("first_grant", 32'(ctrl_command), 32'd2);
    chk("frame_ready_pre", 32'(frame_ready), 32'd0);
    burst(-1);
    burst(-1);
    burst(-1);
    burst(3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_rd_after_disable", 32'(ctrl_command), 32'd0);
    end
    ctrl_read_valid = 1'b1;
    #1;
    chk("valid_outside_read", 32'(fifo_wr_en), 32'd0);
    ctrl_read_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_addr = 0;
    fifo_used = 10'd600;
    rd_enable = 1'b1;
    wr_valid = 1'b1;
    burst(-1);
    wgrant(8, 1'b0, 'h100);
    burst(-1);
    wgrant(3, 1'b1, 'h200);
    burst(-1);
    fifo_used = 10'd100;
    burst(-1);
    fifo_used = 10'd1017;
    wgrant(3, 1'b1, 'h300);
    wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_fifo_idle", 32'(ctrl_command), 32'd0);
    end
    fifo_used = 10'd1016;
    wait_grant(2'd2, "room_grant");
    for (int i = 0; i < 3; i++) begin
      ctrl_read_valid = 1'b1;
      tick();
    end
    #1;
    chk("beat4_push", 32'(fifo_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cmd", 32'(ctrl_command), 32'd0);
    chk("mid_rst_push", 32'(fifo_wr_en), 32'd0);
    chk("mid_rst_frame_ready", 32'(frame_ready), 32'd0);
    chk("mid_rst_grant_rd", 32'(grant_rd), 32'd0);
    tick();
    chk("held_rst_push", 32'(fifo_wr_en), 32'd0);
    ctrl_read_valid = 1'b0;
    rst = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
